// File: rtl/data_mem_resp.sv
// data_mem_resp: word-organised data memory answering CPU load/store requests
// over a valid/ready channel with a one-cycle response pulse after LATENCY edges.
// Optional feature macro: DM_TRACE_EN (prints a trace line per committed store).
module data_mem_resp #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    input  logic [31:0] pc,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic                  accept_c;

    logic                  write_q;
    logic [31:0]           addr_q;
    logic [3:0]            be_q;
    logic [31:0]           wdata_q;
`ifdef DM_TRACE_EN
    logic [31:0]           pc_q;
`endif

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           old_word;
    logic [31:0]           merged;

    // Address bits outside the word index and the pc (trace-only) have no logic role
    logic unused_sink;
    assign unused_sink = ^{pc, addr_q[31:ADDR_WIDTH+2], addr_q[1:0]};

    assign idx      = addr_q[ADDR_WIDTH+1:2];
    assign old_word = mem[idx];

    // State and wait counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic; requests are only looked at in IDLE
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept_c   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept_c = 1'b1;
                    if (LATENCY > 1) begin
                        state_next = WAIT;
                        cnt_next   = CNT_W'(LATENCY - 1);
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = RESP;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt - CNT_W'(1);
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Byte-lane merge of store data over the current word; loads see the whole word
    always_comb begin
        merged = old_word;
        if (write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    // Request capture at acceptance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
`ifdef DM_TRACE_EN
            pc_q    <= '0;
`endif
        end else if (accept_c) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            be_q    <= req_be;
            wdata_q <= req_wdata;
`ifdef DM_TRACE_EN
            pc_q    <= pc;
`endif
        end
    end

    // Registered handshake/response outputs; response issues on the edge leaving RESP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            req_ready  <= (state_next == IDLE);
            resp_valid <= (state == RESP);
            if (state == RESP) resp_rdata <= merged;
        end
    end

    // Memory array: cleared by reset, store committed on the response edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[ADDR_WIDTH'(i)] <= '0;
        end else if (state == RESP && write_q) begin
            mem[idx] <= merged;
`ifdef DM_TRACE_EN
            if (be_q != 4'b0000)
                $display("@%08h: *%08h <= %08h", pc_q, {addr_q[31:2], 2'b00}, merged);
`endif
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: directed self-checking bench for data_mem_resp (LATENCY=2, ADDR_WIDTH=10).
module tb_data_mem_resp;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] pc;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    data_mem_resp #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_be     (req_be),
        .req_wdata  (req_wdata),
        .pc         (pc),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One transaction starting at a negedge with the block idle; returns at the negedge
    // of the response cycle (block idle again there).
    task automatic txn(input string tag, input logic w, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] d, input logic [31:0] p,
                       output logic [31:0] rd);
        check({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_be = be; req_wdata = d; pc = p;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
        check({tag, "_valid_early"}, 32'(resp_valid), 32'd0);
        for (int n = 1; n < LAT; n++) begin
            @(negedge clk);
            check({tag, "_ready_wait"}, 32'(req_ready), 32'd0);
            check({tag, "_valid_wait"}, 32'(resp_valid), 32'd0);
        end
        @(negedge clk);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
        rd = resp_rdata;
    endtask

    logic [31:0] rd;
    int          pulses;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_be = '0; req_wdata = '0; pc = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset applied mid-cycle with no clock edge clears outputs immediately
        txn("pre", 1'b1, 32'h10, 4'hF, 32'hCAFEF00D, 32'h0, rd);
        check("pre_rdata", rd, 32'hCAFEF00D);
        #2 reset = 1'b1;
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        txn("ld10", 1'b0, 32'h10, 4'h0, 32'h0, 32'h0, rd);
        check("ld10_rdata", rd, 32'h0);

        // Word round trip
        txn("st40", 1'b1, 32'h40, 4'hF, 32'hDEADBEEF, 32'h100, rd);
        check("st40_rdata", rd, 32'hDEADBEEF);
        txn("ld40", 1'b0, 32'h40, 4'h0, 32'h0, 32'h104, rd);
        check("ld40_rdata", rd, 32'hDEADBEEF);

        // Byte merge and zero-enable store
        txn("st8", 1'b1, 32'h8, 4'hF, 32'h11223344, 32'h108, rd);
        txn("st8m", 1'b1, 32'h8, 4'b0101, 32'hAABBCCDD, 32'h10C, rd);
        check("st8m_rdata", rd, 32'h11BB33DD);
        txn("ld8", 1'b0, 32'h8, 4'h3, 32'h0, 32'h110, rd);
        check("ld8_rdata", rd, 32'h11BB33DD);
        txn("st8z", 1'b1, 32'h8, 4'h0, 32'hFFFFFFFF, 32'h114, rd);
        check("st8z_rdata", rd, 32'h11BB33DD);
        txn("ld8z", 1'b0, 32'h8, 4'h0, 32'h0, 32'h118, rd);
        check("ld8z_rdata", rd, 32'h11BB33DD);

        // Address wrap and ignored low address bits
        txn("stwrap", 1'b1, 32'h1004, 4'hF, 32'h5, 32'h11C, rd);
        txn("ldwrap", 1'b0, 32'h4, 4'h0, 32'h0, 32'h120, rd);
        check("ldwrap_rdata", rd, 32'h5);
        txn("ldlow", 1'b0, 32'h7, 4'h0, 32'h0, 32'h124, rd);
        check("ldlow_rdata", rd, 32'h5);

        // Back-to-back: load right after store to the same word
        txn("st30", 1'b1, 32'h30, 4'hF, 32'h00000077, 32'h128, rd);
        txn("ld30", 1'b0, 32'h30, 4'h0, 32'h0, 32'h12C, rd);
        check("ld30_rdata", rd, 32'h77);

        // Trace store (printed only when the trace macro is defined)
        txn("sttr", 1'b1, 32'h14, 4'hF, 32'h12345678, 32'h3000, rd);
        check("sttr_rdata", rd, 32'h12345678);

        // req_valid held through edges E0..E0+4: accepts at E0 and E0+3 only
        pulses = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; req_be = 4'h0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        req_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        check("hold_pulses", 32'(pulses), 32'd2);
        check("hold_rdata", resp_rdata, 32'hDEADBEEF);

        // Reset during WAIT drops the store
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_be = 4'hF; req_wdata = 32'h1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("rstw_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        check("rstw_nopulse", 32'(pulses), 32'd0);
        txn("ld20", 1'b0, 32'h20, 4'h0, 32'h0, 32'h130, rd);
        check("ld20_rdata", rd, 32'h0);
        txn("ld40r", 1'b0, 32'h40, 4'h0, 32'h0, 32'h134, rd);
        check("ld40r_rdata", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
